c_select_mofn_pipe: RTL and testbench

- Pipelined, flow-controlled multi-hot select gate for router datapaths (crossbar output combine, VC data muxing).
- Each accepted input combines the selected ports' data words bitwise with a configurable product/sum operator pair, optionally in priority (lowest-index) mode.
- The result travels through num_stages elastic register stages with a valid/ready handshake, so the block can sit on timing-critical paths without stalling throughput.

---
 rtl/c_select_mofn_pipe_pkg.sv | 36 +++
 rtl/c_select_mofn_pipe_stage.sv | 33 +++
 rtl/c_select_mofn_pipe.sv | 98 +++++++++
 tb/tb_c_select_mofn_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_select_mofn_pipe_pkg.sv
// Shared definitions for the pipelined m-of-n select gate: binary operator
// codes, a per-bit operator evaluator and a clog2 helper for counter sizing.
package c_select_mofn_pipe_pkg;

    typedef enum logic [2:0] {
        BINARY_OP_AND  = 3'd0,
        BINARY_OP_NAND = 3'd1,
        BINARY_OP_OR   = 3'd2,
        BINARY_OP_NOR  = 3'd3,
        BINARY_OP_XOR  = 3'd4,
        BINARY_OP_XNOR = 3'd5
    } binary_op_t;

    function automatic logic binary_op(input binary_op_t op, input logic a, input logic b);
        logic r;
        r = a & b;
        case (op)
            BINARY_OP_AND:  r = a & b;
            BINARY_OP_NAND: r = ~(a & b);
            BINARY_OP_OR:   r = a | b;
            BINARY_OP_NOR:  r = ~(a | b);
            BINARY_OP_XOR:  r = a ^ b;
            BINARY_OP_XNOR: r = ~(a ^ b);
            default:        r = a & b;
        endcase
        return r;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/c_select_mofn_pipe_stage.sv
// One elastic register slice: holds a payload while downstream stalls and
// accepts a new word whenever it is empty or being drained this cycle.
module c_pipe_stage #(
    parameter int unsigned width = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [width-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [width-1:0] dn_data
);

    logic             valid;
    logic [width-1:0] data;

    assign up_ready = ~valid | dn_ready;
    assign dn_valid = valid;
    assign dn_data  = data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= (up_valid & up_ready) | (valid & ~dn_ready);
            if (up_valid && up_ready) data <= up_data;
        end
    end

endmodule

// File: rtl/c_select_mofn_pipe.sv
// Flow-controlled multi-hot select gate: combines the selected ports' words
// bitwise, then carries result, popcount and empty flag through elastic stages.
module c_select_mofn_pipe
    import c_select_mofn_pipe_pkg::*;
#(
    parameter int unsigned num_ports  = 4,
    parameter int unsigned width      = 32,
    parameter int unsigned num_stages = 2,
    parameter binary_op_t  prod_op    = BINARY_OP_AND,
    parameter binary_op_t  sum_op     = BINARY_OP_OR,
    parameter int unsigned cnt_width  = clog2(num_ports + 1)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         mode_prio,
    input  logic [0:num_ports-1]         select,
    input  logic [0:num_ports*width-1]   data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [0:width-1]             data_out,
    output logic [cnt_width-1:0]         sel_count,
    output logic                         sel_none
);

    localparam int unsigned payload_width = width + cnt_width + 1;

    logic [0:num_ports-1] esel;
    logic                 found;
    logic [0:width-1]     data_c;
    logic [cnt_width-1:0] cnt_c;
    logic                 none_c;
    logic                 acc;

    // Priority mode keeps only the lowest-index set select bit.
    always_comb begin
        esel  = select;
        found = 1'b0;
        if (mode_prio) begin
            esel = '0;
            for (int unsigned j = 0; j < num_ports; j++) begin
                if (select[j] && !found) begin
                    esel[j] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        data_c = '0;
        acc    = 1'b0;
        for (int unsigned i = 0; i < width; i++) begin
            acc = binary_op(prod_op, data_in[i], esel[0]);
            for (int unsigned j = 1; j < num_ports; j++) begin
                acc = binary_op(sum_op, acc, binary_op(prod_op, data_in[i + j*width], esel[j]));
            end
            data_c[i] = acc;
        end
    end

    always_comb begin
        cnt_c = '0;
        for (int unsigned j = 0; j < num_ports; j++) begin
            cnt_c = cnt_c + cnt_width'(esel[j]);
        end
        none_c = (esel == '0);
    end

    logic [num_stages:0]     stg_valid;
    logic [num_stages:0]     stg_ready;
    logic [payload_width-1:0] stg_data [num_stages+1];

    assign stg_valid[0]          = in_valid;
    assign stg_data[0]           = {data_c, cnt_c, none_c};
    assign in_ready              = stg_ready[0];
    assign stg_ready[num_stages] = out_ready;

    for (genvar k = 0; k < int'(num_stages); k++) begin : g_stage
        c_pipe_stage #(
            .width(payload_width)
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .up_valid (stg_valid[k]),
            .up_ready (stg_ready[k]),
            .up_data  (stg_data[k]),
            .dn_valid (stg_valid[k+1]),
            .dn_ready (stg_ready[k+1]),
            .dn_data  (stg_data[k+1])
        );
    end

    assign out_valid                       = stg_valid[num_stages];
    assign {data_out, sel_count, sel_none} = stg_data[num_stages];

endmodule

// File: tb/tb_c_select_mofn_pipe.sv
// Scoreboard bench for c_select_mofn_pipe (4 ports x 8 bits, 2 stages, AND/OR):
// a driver pushes model results on input transfer, a monitor pops on output transfer.
module tb_c_select_mofn_pipe;

    localparam int NP = 4;
    localparam int W  = 8;
    localparam int NS = 2;

    typedef struct {
        logic [W-1:0] d;
        int           cnt;
        bit           none;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             mode_prio = 1'b0;
    logic [0:NP-1]    select = '0;
    logic [0:NP*W-1]  data_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [0:W-1]     data_out;
    logic [2:0]       sel_count;
    logic             sel_none;

    int checks = 0;
    int errors = 0;
    int n_push = 0;
    int n_pop  = 0;
    exp_t sb[$];

    c_select_mofn_pipe #(
        .num_ports  (NP),
        .width      (W),
        .num_stages (NS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode_prio (mode_prio),
        .select    (select),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .sel_count (sel_count),
        .sel_none  (sel_none)
    );

    always #5 clk = ~clk;

    // Reference: pick effective ports, OR their bytes, count them.
    function automatic exp_t model(input logic [0:NP-1] s, input logic [0:NP*W-1] d, input bit prio);
        exp_t r;
        logic [0:NP-1] eff;
        eff = s;
        if (prio) begin
            eff = '0;
            for (int j = 0; j < NP; j++) begin
                if (s[j]) begin
                    eff[j] = 1'b1;
                    break;
                end
            end
        end
        r.d = '0;
        for (int j = 0; j < NP; j++) if (eff[j]) r.d = r.d | d[j*W +: W];
        r.cnt  = $countones(eff);
        r.none = (eff == '0);
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Drive one cycle's inputs; report whether the word will transfer and out_valid.
    task automatic drive_cycle(input bit v, input logic [0:NP-1] s, input logic [0:NP*W-1] d,
                               input bit prio, input bit ordy, output bit acc, output bit ov);
        @(negedge clk);
        in_valid  = v;
        select    = s;
        data_in   = d;
        mode_prio = prio;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        ov  = out_valid;
        if (acc) begin
            sb.push_back(model(s, d, prio));
            n_push++;
        end
    endtask

    task automatic drain();
        bit acc, ov;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov);
            n++;
        end
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic send_directed(input logic [0:NP-1] s, input logic [0:NP*W-1] d, input bit prio);
        bit acc, ov;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 10) begin
            drive_cycle(1'b1, s, d, prio, 1'b1, acc, ov);
            n++;
        end
        check("directed_accept", acc, 1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov);
        check("latency_not_early", ov, 0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov);
        check("latency_two_cycles", ov, 1);
    endtask

    // Monitor: compares every output transfer and enforces stability under stall.
    initial begin
        bit           prev_stall;
        logic [0:W-1] pd;
        logic [2:0]   pc;
        logic         pn;
        exp_t         e;
        prev_stall = 1'b0;
        pd = '0; pc = '0; pn = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                checks++;
                if (!out_valid || data_out !== pd || sel_count !== pc || sel_none !== pn) begin
                    errors++;
                    $display("FAIL stability: got v=%0b d=%0h c=%0d n=%0b expected v=1 d=%0h c=%0d n=%0b",
                             out_valid, data_out, sel_count, sel_none, pd, pc, pn);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got d=%0h expected no output", data_out);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    if (data_out !== e.d || int'(sel_count) != e.cnt || sel_none !== e.none) begin
                        errors++;
                        $display("FAIL output: got d=%0h c=%0d n=%0b expected d=%0h c=%0d n=%0b",
                                 data_out, sel_count, sel_none, e.d, e.cnt, e.none);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            pd = data_out; pc = sel_count; pn = sel_none;
        end
    end

    initial begin
        bit acc, ov;
        int accepted, k;
        logic [0:NP*W-1] dd;
        logic [0:NP*W-1] words [4];

        dd = {8'h0F, 8'h11, 8'hF0, 8'h22};

        // Power-on reset
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_sel_count", sel_count, 0);
        check("rst_sel_none", sel_none, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed combine and priority cases
        send_directed(4'b1010, dd, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov);
        check("empty_valid_low", ov, 0);
        check("empty_holds_data", data_out, 8'hFF);
        send_directed(4'b0111, dd, 1'b1);
        send_directed(4'b0000, dd, 1'b1);
        send_directed(4'b1111, dd, 1'b0);
        drain();

        // Back-pressure: only num_stages words fit while out_ready is low
        for (int i = 0; i < 4; i++) words[i] = {$urandom};
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 4'($urandom_range(0, 15)), words[accepted < 4 ? accepted : 3],
                        1'b0, 1'b0, acc, ov);
            check("bp_in_ready", acc, accepted < NS);
            if (acc) accepted++;
        end
        drive_cycle(1'b1, 4'b1100, words[accepted], 1'b0, 1'b1, acc, ov);
        check("full_reopen_same_cycle", acc, 1);
        if (acc) accepted++;
        k = 0;
        while (accepted < 4 && k < 20) begin
            drive_cycle(1'b1, 4'b0110, words[accepted], 1'b0, 1'b1, acc, ov);
            if (acc) accepted++;
            k++;
        end
        check("bp_all_accepted", accepted, 4);
        drain();

        // Throughput: back-to-back words with out_ready high
        for (int t = 0; t < 103; t++) begin
            drive_cycle(t < 100, 4'($urandom_range(0, 15)), {$urandom}, 1'($urandom), 1'b1, acc, ov);
            if (t < 100) check("tput_in_ready", acc, 1);
            check("tput_out_valid", ov, (t >= NS && t < 100 + NS));
        end
        drain();

        // Random traffic
        for (int t = 0; t < 500; t++) begin
            drive_cycle(1'($urandom), 4'($urandom_range(0, 15)), {$urandom}, 1'($urandom),
                        1'($urandom), acc, ov);
        end
        drain();

        // Mid-stream asynchronous reset discards in-flight words
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'b1111, {$urandom}, 1'b0, 1'b0, acc, ov);
        @(negedge clk);
        in_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_sel_count", sel_count, 0);
        check("midrst_in_ready", in_ready, 1);
        n_push = n_push - sb.size();
        sb.delete();
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b1;
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov);
        check("post_rst_no_output", ov, 0);
        send_directed(4'b0101, dd, 1'b0);
        drain();

        check("no_loss_or_dup", n_pop, n_push);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
